nn_axis_result_tx: RTL and testbench
====================================

Name: nn_axis_result_tx

Overview:
- AXI-Stream master transmitter for network results; the output-side counterpart of the always-ready `axis_in` receiver.
- Captures the final layer's parallel output vector and the maxFinder class index in one cycle.
- Serialises them as one packet on `m_axis`, honouring `tready` backpressure and marking the last beat with `tlast`.
- Sits between the last Layer/maxFinder and an external DMA. Replaces the AXI-lite `axi_rd_en` shift-out path for streaming use.

Parameters:
- NUM_OUT, 10: neurons in the final layer, i.e. data beats per packet (>=1).
- DATA_WIDTH, 16: width of each neuron output and of `m_axis_tdata`.
- APPEND_CLASS, 1: when 1, one extra beat carrying the class index is sent after the neuron beats.
- CNT_WIDTH, 16: width of the frame and drop counters.

Ports:
- s_axi_aclk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  one-cycle strobe; `in_data`/`in_class` valid
- in_data  in  NUM_OUT*DATA_WIDTH  neuron outputs; neuron 0 in bits [DATA_WIDTH-1:0]
- in_class  in  32  maxFinder class index
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last beat of packet
- busy  out  1  a packet is in flight or pending
- frame_count  out  CNT_WIDTH  packets fully sent; wraps
- drop_count  out  CNT_WIDTH  frames dropped on overflow; saturates at all-ones

Behaviour:
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, frame_count=0, drop_count=0. State is IDLE; the pending slot is empty.
- Packet length: L = NUM_OUT + APPEND_CLASS beats.
- Beat contents:
  - Beat k (k < NUM_OUT) = neuron k.
  - Class beat = in_class[DATA_WIDTH-1:0], zero-extended if DATA_WIDTH > 32.
- Storage:
  - Hold register: frame currently being sent, plus beat counter `idx`.
  - Pending slot: one full frame plus its flag.
- IDLE:
  - in_valid -> load hold, set idx=0, go to SEND.
  - tvalid=1 and beat 0 on tdata from the next cycle (latency 1).
- SEND:
  - tdata = beat[idx]; tlast = (idx == L-1).
  - Handshake (tvalid & tready) on a non-last beat: idx++.
  - No handshake: tdata, tlast and tvalid stay stable. tvalid never drops mid-packet.
- Last-beat handshake:
  - frame_count++.
  - If pending is full: load pending into hold, idx=0, clear pending, stay in SEND with tvalid held high (no bubble).
  - Else if in_valid this cycle: load in_data directly into hold, same no-bubble behaviour.
  - Else: go to IDLE; tvalid=0 next cycle.
- in_valid while in SEND, not on a last-beat handshake:
  - Pending empty: capture into pending.
  - Pending full: discard the new frame and increment drop_count (saturating). Pending keeps the older frame.
- Last-beat handshake + in_valid + pending full: pending moves to hold, new frame goes to pending, no drop.
- busy = (state == SEND) | pending_valid.
- reset asserted mid-packet:
  - All state cleared next cycle and tvalid=0.
  - The packet is truncated without tlast. This is accepted for softReset; downstream must resync.
- NUM_OUT=1, APPEND_CLASS=0: every beat has tlast=1.

Decomposition:
- Shared package/include:
  - Default DATA_WIDTH, tied to `dataWidth`.
  - Default NUM_OUT, tied to `numNeuronLayer4`.
  - State encoding localparams IDLE/SEND.
- Sub-module `nn_frame_slot`: one-frame register with load/clear/valid flag. Instantiated twice, for hold and pending.
- Beat mux and control FSM stay in the top of this block.

Test Plan:
- Basic packet: NUM_OUT=4, DW=16, in_data={0x0004,0x0003,0x0002,0x0001}, in_class=2, tready=1 -> beats 1,2,3,4,2 on consecutive cycles starting 1 cycle after in_valid; tlast only on 5th beat; frame_count=1.
- Backpressure: same frame, tready toggling 1,0,0,1,... -> tdata/tlast stable while tready=0; 5 beats delivered in order; tvalid never drops before tlast.
- Back-to-back: second in_valid (data 0x10..0x13, class 0) during packet 1 -> zero-cycle gap after tlast; second packet 0x10,0x11,0x12,0x13,0; frame_count=2; drop_count=0.
- Overflow: tready=0, three in_valid strobes (frames A,B,C) -> A sent, then B; C dropped; drop_count=1; busy high until B's tlast.
- Simultaneous: in_valid coincident with last-beat handshake, pending empty -> new frame's beat 0 on the next cycle, no bubble; with pending full -> pending sent next, new frame kept, drop_count unchanged.
- Reset mid-packet: reset on beat 2 -> tvalid=0 next cycle; counters 0; next in_valid starts a fresh packet from beat 0.

Source files
------------

// File: rtl/nn_axis_result_tx_pkg.sv
// Shared defaults and state encoding for the network-result AXI-Stream transmitter.
package nn_axis_result_tx_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;  // dataWidth
    localparam int unsigned NUM_OUT_DEF    = 10;  // numNeuronLayer4

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/nn_frame_slot.sv
// One-frame register with load/clear and a valid flag; used for the hold and pending slots.
module nn_frame_slot
    import nn_axis_result_tx_pkg::*;
#(
    parameter int unsigned NUM_BEATS  = NUM_OUT_DEF + 1,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                                 s_axi_aclk,
    input  logic                                 reset,
    input  logic                                 load,
    input  logic                                 clear,
    input  logic [NUM_BEATS-1:0][DATA_WIDTH-1:0] d,
    output logic [NUM_BEATS-1:0][DATA_WIDTH-1:0] q,
    output logic                                 valid
);

    // Load wins over clear so a slot can be emptied and refilled in the same cycle.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nn_axis_result_tx.sv
// Captures the final-layer output vector plus class index and streams it as one AXI-Stream packet.
module nn_axis_result_tx
    import nn_axis_result_tx_pkg::*;
#(
    parameter int unsigned NUM_OUT      = NUM_OUT_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned APPEND_CLASS = 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                          s_axi_aclk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [NUM_OUT*DATA_WIDTH-1:0] in_data,
    input  logic [31:0]                   in_class,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          frame_count,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    localparam int unsigned NUM_BEATS = NUM_OUT + APPEND_CLASS;
    localparam int unsigned IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned LAST_IDX  = NUM_BEATS - 1;
    localparam logic        SINGLE    = (NUM_BEATS == 1);

    tx_state_t state, state_n;
    logic [IDX_W-1:0] idx, idx_n, idx_inc;
    logic [DATA_WIDTH-1:0] tdata_n, class_beat;
    logic tvalid_n, tlast_n, handshake, at_last;
    logic hold_load, hold_clear, hold_from_pend, hold_valid;
    logic pend_load, pend_clear, pend_valid, pend_valid_n;
    logic frame_inc, drop_inc;
    logic [NUM_BEATS-1:0][DATA_WIDTH-1:0] in_beats, hold_d, hold_q, pend_q;
    logic unused_bits;

    generate
        if (DATA_WIDTH <= 32) begin : g_class_narrow
            assign class_beat = in_class[DATA_WIDTH-1:0];
        end else begin : g_class_wide
            assign class_beat = DATA_WIDTH'(in_class);
        end
        if (APPEND_CLASS != 0) begin : g_append
            assign in_beats = {class_beat, in_data};
        end else begin : g_no_append
            assign in_beats = in_data;
        end
    endgenerate

    assign unused_bits = ^{in_class, class_beat, hold_valid};
    assign hold_d      = hold_from_pend ? pend_q : in_beats;

    nn_frame_slot #(.NUM_BEATS(NUM_BEATS), .DATA_WIDTH(DATA_WIDTH)) u_hold (
        .s_axi_aclk (s_axi_aclk),
        .reset      (reset),
        .load       (hold_load),
        .clear      (hold_clear),
        .d          (hold_d),
        .q          (hold_q),
        .valid      (hold_valid)
    );

    nn_frame_slot #(.NUM_BEATS(NUM_BEATS), .DATA_WIDTH(DATA_WIDTH)) u_pend (
        .s_axi_aclk (s_axi_aclk),
        .reset      (reset),
        .load       (pend_load),
        .clear      (pend_clear),
        .d          (in_beats),
        .q          (pend_q),
        .valid      (pend_valid)
    );

    assign handshake    = m_axis_tvalid & m_axis_tready;
    assign idx_inc      = idx + IDX_W'(1);
    assign at_last      = (idx == IDX_W'(LAST_IDX));
    assign pend_valid_n = pend_load | (pend_valid & ~pend_clear);

    // Next-state, beat mux and slot control; a new frame presents beat 0 on the cycle after it loads.
    always_comb begin
        state_n        = state;
        idx_n          = idx;
        tdata_n        = m_axis_tdata;
        tlast_n        = m_axis_tlast;
        tvalid_n       = m_axis_tvalid;
        hold_load      = 1'b0;
        hold_clear     = 1'b0;
        hold_from_pend = 1'b0;
        pend_load      = 1'b0;
        pend_clear     = 1'b0;
        frame_inc      = 1'b0;
        drop_inc       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    hold_load = 1'b1;
                    state_n   = SEND;
                    idx_n     = '0;
                    tvalid_n  = 1'b1;
                    tdata_n   = in_beats[0];
                    tlast_n   = SINGLE;
                end
            end
            SEND: begin
                if (handshake && at_last) begin
                    frame_inc = 1'b1;
                    if (pend_valid) begin
                        hold_load      = 1'b1;
                        hold_from_pend = 1'b1;
                        pend_clear     = 1'b1;
                        pend_load      = in_valid;
                        idx_n          = '0;
                        tdata_n        = pend_q[0];
                        tlast_n        = SINGLE;
                    end else if (in_valid) begin
                        hold_load = 1'b1;
                        idx_n     = '0;
                        tdata_n   = in_beats[0];
                        tlast_n   = SINGLE;
                    end else begin
                        hold_clear = 1'b1;
                        state_n    = IDLE;
                        tvalid_n   = 1'b0;
                        tlast_n    = 1'b0;
                        tdata_n    = '0;
                    end
                end else begin
                    if (handshake) begin
                        idx_n   = idx_inc;
                        tdata_n = hold_q[idx_inc];
                        tlast_n = (idx_inc == IDX_W'(LAST_IDX));
                    end
                    if (in_valid) begin
                        if (!pend_valid) pend_load = 1'b1;
                        else             drop_inc  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            frame_count   <= '0;
            drop_count    <= '0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            m_axis_tdata  <= tdata_n;
            m_axis_tvalid <= tvalid_n;
            m_axis_tlast  <= tlast_n;
            busy          <= (state_n == SEND) | pend_valid_n;
            if (frame_inc) frame_count <= frame_count + CNT_WIDTH'(1);
            if (drop_inc && (drop_count != '1)) drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_nn_axis_result_tx.sv
// Directed bench for nn_axis_result_tx with NUM_OUT=4, DATA_WIDTH=16, class beat appended.
module tb_nn_axis_result_tx;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic [31:0] in_class;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        busy;
    logic [15:0] fc;
    logic [15:0] dc;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] DATA_A = 64'h0004_0003_0002_0001;
    localparam logic [63:0] DATA_B = 64'h0013_0012_0011_0010;
    localparam logic [63:0] DATA_C = 64'h00C4_00C3_00C2_00C1;
    localparam logic [79:0] EXP_A  = {16'h0002, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    localparam logic [79:0] EXP_B  = {16'h0000, 16'h0013, 16'h0012, 16'h0011, 16'h0010};
    localparam logic [79:0] EXP_C  = {16'h0007, 16'h00C4, 16'h00C3, 16'h00C2, 16'h00C1};

    nn_axis_result_tx #(
        .NUM_OUT      (4),
        .DATA_WIDTH   (16),
        .APPEND_CLASS (1),
        .CNT_WIDTH    (16)
    ) dut (
        .s_axi_aclk    (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_class      (in_class),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .busy          (busy),
        .frame_count   (fc),
        .drop_count    (dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [63:0] d, input logic [31:0] c);
        in_data  = d;
        in_class = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Consumes one 5-beat packet; bp=1 drives tready 1,0,0,1,0,0,...; optional in_valid at cycle inj_at.
    task automatic recv_packet(input string tag, input logic [79:0] exp, input int bp,
                               input int inj_at, input logic [63:0] inj_d, input logic [31:0] inj_c);
        int k = 0;
        int cyc = 0;
        logic [15:0] prev_d = '0;
        logic prev_l = 1'b0;
        logic stalled = 1'b0;
        logic [15:0] e;
        while (k < 5 && cyc < 40) begin
            tready = (bp == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (cyc == inj_at) begin
                in_data  = inj_d;
                in_class = inj_c;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk({tag, "_tvalid"}, 32'(tvalid), 32'd1);
            if (stalled) begin
                chk({tag, "_stable_d"}, 32'(tdata), 32'(prev_d));
                chk({tag, "_stable_l"}, 32'(tlast), 32'(prev_l));
            end
            if (tready) begin
                e = exp[k*16 +: 16];
                chk({tag, "_d"}, 32'(tdata), 32'(e));
                chk({tag, "_l"}, 32'(tlast), 32'(k == 4));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev_d  = tdata;
                prev_l  = tlast;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_beats"}, 32'(k), 32'd5);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_class = '0;
        tready   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fc", 32'(fc), 32'd0);
        chk("rst_dc", 32'(dc), 32'd0);

        // Basic packet
        tready = 1'b1;
        chk("basic_pre_tvalid", 32'(tvalid), 32'd0);
        drive_frame(DATA_A, 32'd2);
        recv_packet("basic", EXP_A, 0, -1, '0, '0);
        chk("basic_idle_tvalid", 32'(tvalid), 32'd0);
        chk("basic_busy", 32'(busy), 32'd0);
        chk("basic_fc", 32'(fc), 32'd1);

        // Backpressure
        tready = 1'b0;
        drive_frame(DATA_A, 32'd2);
        recv_packet("bp", EXP_A, 1, -1, '0, '0);
        chk("bp_fc", 32'(fc), 32'd2);

        // Back-to-back via pending slot
        tready = 1'b1;
        drive_frame(DATA_A, 32'd2);
        recv_packet("b2b_a", EXP_A, 0, 2, DATA_B, 32'd0);
        recv_packet("b2b_b", EXP_B, 0, -1, '0, '0);
        chk("b2b_fc", 32'(fc), 32'd4);
        chk("b2b_dc", 32'(dc), 32'd0);

        // Overflow: third frame dropped
        tready = 1'b0;
        drive_frame(DATA_A, 32'd2);
        drive_frame(DATA_B, 32'd0);
        drive_frame(DATA_C, 32'd7);
        chk("ovf_dc", 32'(dc), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd1);
        recv_packet("ovf_a", EXP_A, 0, -1, '0, '0);
        chk("ovf_busy_mid", 32'(busy), 32'd1);
        recv_packet("ovf_b", EXP_B, 0, -1, '0, '0);
        chk("ovf_busy_end", 32'(busy), 32'd0);
        chk("ovf_tvalid_end", 32'(tvalid), 32'd0);
        chk("ovf_fc", 32'(fc), 32'd6);

        // Simultaneous in_valid with last beat, pending empty
        tready = 1'b1;
        drive_frame(DATA_A, 32'd2);
        recv_packet("sim0_a", EXP_A, 0, 4, DATA_B, 32'd0);
        recv_packet("sim0_b", EXP_B, 0, -1, '0, '0);
        chk("sim0_fc", 32'(fc), 32'd8);

        // Simultaneous in_valid with last beat, pending full
        tready = 1'b0;
        drive_frame(DATA_A, 32'd2);
        drive_frame(DATA_B, 32'd0);
        recv_packet("sim1_a", EXP_A, 0, 4, DATA_C, 32'd7);
        recv_packet("sim1_b", EXP_B, 0, -1, '0, '0);
        recv_packet("sim1_c", EXP_C, 0, -1, '0, '0);
        chk("sim1_dc", 32'(dc), 32'd1);
        chk("sim1_fc", 32'(fc), 32'd11);
        chk("sim1_busy", 32'(busy), 32'd0);

        // Reset mid-packet on beat 2
        tready = 1'b1;
        drive_frame(DATA_A, 32'd2);
        step();
        step();
        chk("rstm_beat2", 32'(tdata), 32'h3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstm_tvalid", 32'(tvalid), 32'd0);
        chk("rstm_tlast", 32'(tlast), 32'd0);
        chk("rstm_fc", 32'(fc), 32'd0);
        chk("rstm_dc", 32'(dc), 32'd0);
        chk("rstm_busy", 32'(busy), 32'd0);
        drive_frame(DATA_B, 32'd0);
        recv_packet("rstm_b", EXP_B, 0, -1, '0, '0);
        chk("rstm_fc_after", 32'(fc), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
